// File: rtl/framebuffer_pkg.sv
// Shared constants, state encoding and clipping helper for the framebuffer
// fill engine.
package framebuffer_pkg;

    localparam int SCREEN_W = 400;
    localparam int SCREEN_H = 240;
    localparam int FB_WORDS = 96000;
    localparam int ADDR_W   = 17;
    localparam int PIXEL_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // Exclusive end coordinate clipped to the screen edge.
    function automatic logic [9:0] clip_end(input logic [9:0] sum_v, input logic [9:0] limit_v);
        logic [9:0] res_v;
        if (sum_v > limit_v) begin
            res_v = limit_v;
        end else begin
            res_v = sum_v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/framebuffer_fill.sv
// Rectangle fill engine: clips a fill command to the screen and streams one
// pixel write per granted cycle into framebuffer port A.
module framebuffer_fill
    import framebuffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8:0]           x0,
    input  logic [7:0]           y0,
    input  logic [8:0]           w,
    input  logic [7:0]           h,
    input  logic [PIXEL_W-1:0]   color,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    fb_address,
    output logic [PIXEL_W-1:0]   fb_dataOut,
    output logic                 fb_writeEnable,
    input  logic                 fb_grant
);

    fill_state_t        state_r;
    logic [8:0]         x0_r;
    logic [7:0]         y0_r;
    logic [8:0]         w_r;
    logic [7:0]         h_r;
    logic [PIXEL_W-1:0] color_r;
    logic [9:0]         x_end_r;
    logic [9:0]         y_end_r;
    logic [9:0]         x_r;
    logic [9:0]         y_r;
    logic [ADDR_W-1:0]  row_base_r;

    logic [9:0]         x_end_s;
    logic [9:0]         y_end_s;
    logic               empty_s;
    logic [ADDR_W-1:0]  row_base_s;
    logic [ADDR_W-1:0]  first_addr_s;
    logic [9:0]         x_next_s;
    logic [9:0]         y_next_s;
    logic               row_end_s;
    logic               last_row_s;
    logic [ADDR_W-1:0]  next_row_base_s;
    logic [ADDR_W-1:0]  next_row_addr_s;

    // Setup-time clipping and the loop's next-step address arithmetic.
    always_comb begin
        x_end_s = clip_end({1'b0, x0_r} + {1'b0, w_r}, 10'(SCREEN_W));
        y_end_s = clip_end({2'b00, y0_r} + {2'b00, h_r}, 10'(SCREEN_H));
        empty_s = (x0_r >= 9'(SCREEN_W)) || (y0_r >= 8'(SCREEN_H)) ||
                  (w_r == 9'd0) || (h_r == 8'd0);
        // y0*400 as shifts: 400 = 256 + 128 + 16
        row_base_s = ({9'd0, y0_r} << 8) + ({9'd0, y0_r} << 7) + ({9'd0, y0_r} << 4);
        first_addr_s    = row_base_s + {8'd0, x0_r};
        x_next_s        = x_r + 10'd1;
        y_next_s        = y_r + 10'd1;
        row_end_s       = (x_next_s >= x_end_r);
        last_row_s      = (y_next_s >= y_end_r);
        next_row_base_s = row_base_r + ADDR_W'(SCREEN_W);
        next_row_addr_s = next_row_base_s + {8'd0, x0_r};
    end

    // Fill FSM with coordinate/address counters and registered port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            fb_address     <= '0;
            fb_dataOut     <= '0;
            fb_writeEnable <= 1'b0;
            x0_r           <= 9'd0;
            y0_r           <= 8'd0;
            w_r            <= 9'd0;
            h_r            <= 8'd0;
            color_r        <= '0;
            x_end_r        <= 10'd0;
            y_end_r        <= 10'd0;
            x_r            <= 10'd0;
            y_r            <= 10'd0;
            row_base_r     <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        x0_r    <= x0;
                        y0_r    <= y0;
                        w_r     <= w;
                        h_r     <= h;
                        color_r <= color;
                        busy    <= 1'b1;
                        state_r <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    x_end_r <= x_end_s;
                    y_end_r <= y_end_s;
                    if (empty_s) begin
                        state_r <= DONE;
                    end else begin
                        x_r            <= {1'b0, x0_r};
                        y_r            <= {2'b00, y0_r};
                        row_base_r     <= row_base_s;
                        fb_address     <= first_addr_s;
                        fb_dataOut     <= color_r;
                        fb_writeEnable <= 1'b1;
                        state_r        <= FILL;
                    end
                end
                FILL: begin
                    if (fb_grant) begin
                        if (!row_end_s) begin
                            x_r        <= x_next_s;
                            fb_address <= fb_address + ADDR_W'(1);
                        end else if (!last_row_s) begin
                            // next-row address is ready, so the wrap costs no cycle
                            x_r        <= {1'b0, x0_r};
                            y_r        <= y_next_s;
                            row_base_r <= next_row_base_s;
                            fb_address <= next_row_addr_s;
                        end else begin
                            fb_writeEnable <= 1'b0;
                            state_r        <= DONE;
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    fb_writeEnable <= 1'b0;
                    busy           <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_fill.sv
// Self-checking bench for framebuffer_fill: directed and random fill commands
// compared against an arithmetic model of the clipped rectangle.
module tb_framebuffer_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [15:0] color;
    logic        busy;
    logic        done;
    logic [16:0] fb_address;
    logic [15:0] fb_dataOut;
    logic        fb_writeEnable;
    logic        fb_grant;

    framebuffer_fill dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
        .busy(busy), .done(done),
        .fb_address(fb_address), .fb_dataOut(fb_dataOut),
        .fb_writeEnable(fb_writeEnable), .fb_grant(fb_grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int start_cyc, done_cyc, first_w;
    int exp_q[$];
    int got_a[$];
    int got_d[$];
    bit pat[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_cmd(input int ax0, input int ay0, input int aw, input int ah, input int acol);
        x0    = ax0[8:0];
        y0    = ay0[7:0];
        w     = aw[8:0];
        h     = ah[7:0];
        color = acol[15:0];
        start = 1'b1;
    endtask

    // Expects start already driven at a sample point; runs the command to done.
    task automatic run_cmd(input string tag, input int ax0, input int ay0, input int aw,
                           input int ah, input int acol, input int gmode, input int inject,
                           input bit chain, input int nx0, input int ny0, input int nw,
                           input int nh, input int ncol);
        logic        g;
        logic        pwe, pg;
        logic [16:0] pa;
        logic [15:0] pd;
        int          n;
        exp_q.delete();
        got_a.delete();
        got_d.delete();
        for (int yy = ay0; yy < ay0 + ah && yy < 240; yy++)
            for (int xx = ax0; xx < ax0 + aw && xx < 400; xx++)
                exp_q.push_back(yy * 400 + xx);

        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        done_cyc = -1;
        first_w  = -1;
        pwe = 1'b0; pg = 1'b0; pa = '0; pd = '0; n = 0;
        for (int k = 0; k < 30000 && done_cyc < 0; k++) begin
            if (pwe && !pg) begin
                check({tag, "_stall_addr"}, fb_address, pa);
                check({tag, "_stall_data"}, fb_dataOut, pd);
                check({tag, "_stall_we"}, fb_writeEnable, 1);
            end
            if (done) begin
                done_cyc = cyc;
                check({tag, "_busy_at_done"}, busy, 0);
            end else begin
                case (gmode)
                    0:       g = 1'b1;
                    1:       g = 1'($urandom_range(0, 1));
                    default: g = (n < 7) ? pat[n] : 1'b1;
                endcase
                fb_grant = g;
                n++;
                if (k == inject) begin
                    x0 = 9'd0; y0 = 8'd0; w = 9'd1; h = 8'd1; color = 16'hDEAD;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (fb_writeEnable && g) begin
                    if (first_w < 0) first_w = cyc + 1;
                    got_a.push_back(int'(fb_address));
                    got_d.push_back(int'(fb_dataOut));
                end
                pwe = fb_writeEnable; pg = g; pa = fb_address; pd = fb_dataOut;
                @(posedge clk); #1;
            end
        end
        check({tag, "_done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
        check({tag, "_write_count"}, got_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            check({tag, "_addr"}, got_a[i], exp_q[i]);
            check({tag, "_data"}, got_d[i], acol & 16'hFFFF);
        end
        if (gmode == 0) begin
            check({tag, "_done_latency"}, done_cyc - start_cyc, 2 + exp_q.size());
            if (exp_q.size() > 0)
                check({tag, "_first_write"}, first_w - start_cyc, 2);
        end
        if (chain) begin
            drive_cmd(nx0, ny0, nw, nh, ncol);
        end else begin
            start = 1'b0;
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_idle_busy"}, busy, 0);
        end
    endtask

    initial begin
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        reset = 1'b1; start = 1'b0; fb_grant = 1'b0;
        x0 = 9'd0; y0 = 8'd0; w = 9'd0; h = 8'd0; color = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", fb_writeEnable, 0);
        check("rst_addr", fb_address, 0);
        check("rst_data", fb_dataOut, 0);
        reset = 1'b0;

        drive_cmd(10, 5, 3, 2, 16'hF800);
        run_cmd("small", 10, 5, 3, 2, 16'hF800, 0, -1, 0, 0, 0, 0, 0, 0);
        drive_cmd(398, 239, 5, 4, 16'h1234);
        run_cmd("clip", 398, 239, 5, 4, 16'h1234, 0, -1, 0, 0, 0, 0, 0, 0);
        drive_cmd(400, 10, 5, 5, 16'h5555);
        run_cmd("empty_x", 400, 10, 5, 5, 16'h5555, 0, -1, 0, 0, 0, 0, 0, 0);
        drive_cmd(10, 10, 0, 5, 16'h6666);
        run_cmd("empty_w", 10, 10, 0, 5, 16'h6666, 0, -1, 0, 0, 0, 0, 0, 0);
        drive_cmd(0, 0, 2, 2, 16'h07E0);
        run_cmd("stall", 0, 0, 2, 2, 16'h07E0, 2, -1, 0, 0, 0, 0, 0, 0);

        drive_cmd(20, 20, 5, 3, 16'h001F);
        run_cmd("busy_ign", 20, 20, 5, 3, 16'h001F, 0, 3, 1, 100, 100, 2, 2, 16'hABCD);
        run_cmd("b2b", 100, 100, 2, 2, 16'hABCD, 0, -1, 0, 0, 0, 0, 0, 0);

        // Reset while the third pixel of a long row is on the port.
        drive_cmd(0, 10, 400, 1, 16'h4321);
        fb_grant = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_addr3", fb_address, 4002);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_we", fb_writeEnable, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_addr", fb_address, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_mid_no_done", done, 0);
        end
        drive_cmd(5, 0, 4, 1, 16'h0F0F);
        run_cmd("post_rst", 5, 0, 4, 1, 16'h0F0F, 0, -1, 0, 0, 0, 0, 0, 0);

        drive_cmd(0, 200, 400, 40, 16'h0000);
        run_cmd("clear", 0, 200, 400, 40, 16'h0000, 0, -1, 0, 0, 0, 0, 0, 0);
        drive_cmd(390, 230, 511, 255, 16'hFFFF);
        run_cmd("oversize", 390, 230, 511, 255, 16'hFFFF, 0, -1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            int rx, ry, rw, rh, rc;
            rx = int'($urandom_range(0, 410));
            ry = int'($urandom_range(0, 245));
            rw = int'($urandom_range(0, 12));
            rh = int'($urandom_range(0, 5));
            rc = int'($urandom_range(0, 65535));
            drive_cmd(rx, ry, rw, rh, rc);
            run_cmd("rnd", rx, ry, rw, rh, rc, 1, -1, 0, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/framebuffer_fill.md
Name: framebuffer_fill

Overview:
- Rectangle fill engine that sits directly upstream of the framebuffer's port A.
- Accepts a fill command (origin, size, 16-bit colour), clips it to the 400x240 screen and writes one pixel per granted cycle.
- Shares port A with the CPU path through an external arbiter; a grant input stalls the engine.
- Used for screen clear and solid-rectangle primitives.

Parameters:
- SCREEN_W, 400, pixels per row; row stride in words.
- SCREEN_H, 240, rows.
- ADDR_W, 17, framebuffer word-address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- x0  in  9  left column of rectangle.
- y0  in  8  top row of rectangle.
- w  in  9  width in pixels.
- h  in  8  height in rows.
- color  in  16  fill value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- fb_address  out  ADDR_W  word address = y*SCREEN_W + x.
- fb_dataOut  out  16  write data (registered colour).
- fb_writeEnable  out  1  write request.
- fb_grant  in  1  arbiter grant; a write completes in a cycle where fb_writeEnable and fb_grant are both high.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset forces state IDLE and busy=0, done=0, fb_writeEnable=0, fb_address=0, fb_dataOut=0 at the next edge. This holds mid-fill: the pending write is dropped and no done pulse is issued.
- State IDLE: start=1 latches x0, y0, w, h and color, then goes to SETUP. busy rises on the next cycle.
- Start while busy=1: ignored, with no effect on the running fill.
- State SETUP (1 cycle) computes:
  - x_end = min(x0+w, SCREEN_W) and y_end = min(y0+h, SCREEN_H), using 10-bit sums so there is no wrap.
  - row_base = y0*SCREEN_W (constant multiply).
  - Empty rectangle: x0>=SCREEN_W, y0>=SCREEN_H, w=0 or h=0. Go to DONE with no write issued.
  - Otherwise go to FILL with x=x0, y=y0 and fb_address=row_base+x0.
- State FILL:
  - fb_writeEnable=1, fb_dataOut=color.
  - fb_grant=0: address, data and writeEnable are held stable.
  - fb_grant=1: the write completes and the engine advances.
  - Advance within a row: x+1 < x_end gives x+=1, address+=1.
  - Row end, more rows left: x=x0, y+=1, row_base+=SCREEN_W, address=row_base+SCREEN_W+x0.
  - Last pixel (x+1=x_end and y+1=y_end): fb_writeEnable=0 next cycle, go to DONE.
- Throughput: one pixel per cycle with continuous grant. No bubble at row wrap; next-row address is precomputed.
- Addressing: no multiplier inside the FILL loop. Maximum address is 95999 (< 2^17).
- State DONE (1 cycle): done=1, busy=0 in the same cycle, then IDLE.
- Restart: a start sampled in the cycle after DONE is accepted, giving back-to-back commands.
- Latency with full grant: start edge to first write = 2 cycles; total busy cycles = 2 + clipped pixel count.
- fb_dataOut is don't-care while fb_writeEnable=0; it is driven with the colour for the whole FILL.

Decomposition:
- Package framebuffer_pkg holds:
  - SCREEN_W, SCREEN_H, FB_WORDS=96000, ADDR_W=17, PIXEL_W=16.
  - The fill_state_t enum {IDLE, SETUP, FILL, DONE}.
- No sub-module; the FSM and the address/coordinate counters are one block.
- Optional helper: fill_clip, a combinational min/empty check. Inline it if it is under 20 lines.

Test Plan:
- Full-screen clear: x0=0, y0=0, w=400, h=240, color=16'h0000, grant always 1 → exactly 96000 writes at addresses 0..95999 in order; done pulses at cycle 96002 after start.
- Small rectangle: x0=10, y0=5, w=3, h=2, color=16'hF800 → writes to 2010, 2011, 2012, 2410, 2411, 2412, with no gap cycle at the row wrap.
- Clipping and empty commands:
  - x0=398, y0=239, w=5, h=4 → writes only 95998 and 95999.
  - x0=400 or w=0 → zero writes, done 2 cycles after start.
- Grant stall: 2x2 fill at (0,0) with fb_grant toggling 1,0,0,1,0,1,1 → address and data stable during low-grant cycles; exactly 4 writes, to 0, 1, 400, 401.
- Start while busy and back-to-back: a second start during a fill is ignored. A start in the cycle after done launches the new command, which produces its first write 2 cycles later.
- Mid-fill reset: reset asserted during the 3rd write of a 400-pixel row → fb_writeEnable=0 and busy=0 next cycle, no done pulse; a subsequent command runs normally.
